// File: rtl/soc_system_pio_capture.sv
// soc_system_pio_capture
//   Avalon-MM input PIO with synchroniser, optional debounce, programmable
//   edge/level event detection, write-1-to-clear capture register and a
//   maskable level interrupt.
//
// Parameters
//   WIDTH     input bus width (1..32)
//   DEBOUNCE  cycles an input must differ from its stable value before it is
//             accepted; 0 or 1 disables filtering
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     register word address (0 DATA, 1 MODE, 2 MASK, 3 CAP)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, latency 1, updated every cycle
//   irq         |(cap & mask)
module soc_system_pio_capture #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEBOUNCE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    MODE_RISE  = 2'b00,
    MODE_FALL  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_LEVEL = 2'b11
  } mode_e;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  mode_e            mode_q, mode_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise, fall, evt, clr;
  logic             unused_wdata;

  // Upper write-data bits are meaningless for narrow instances.
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    s1_d   = in_port;
    s2_d   = s1_q;
    prev_d = stable_q;

    rise = stable_q & ~prev_q;
    fall = prev_q & ~stable_q;
    case (mode_q)
      MODE_RISE:  evt = rise;
      MODE_FALL:  evt = fall;
      MODE_BOTH:  evt = rise | fall;
      MODE_LEVEL: evt = stable_q;
      default:    evt = '0;
    endcase

    clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // New events are OR-ed in after the clear, so a same-cycle set wins.
    cap_d = (cap_q & ~clr) | evt;

    mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    mode_d = (wr_en && address == 2'd1) ? mode_e'(writedata[1:0]) : mode_q;

    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = stable_q;
      2'd1:    readdata_d[1:0]       = mode_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d[WIDTH-1:0] = cap_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      cap_q      <= '0;
      mask_q     <= '0;
      mode_q     <= MODE_RISE;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
    end
  end

  generate
    if (DEBOUNCE >= 2) begin : g_debounce
      localparam int unsigned CW = $clog2(DEBOUNCE);
      localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

      logic [CW-1:0]    cnt_q [WIDTH];
      logic [CW-1:0]    cnt_d [WIDTH];
      logic [WIDTH-1:0] stable_d;

      // Counter runs only while the synchronised input disagrees with the
      // stable value; any agreement restarts it, so short glitches vanish.
      always_comb begin
        stable_d = stable_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          cnt_d[i] = cnt_q[i];
          if (s2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable_q <= '0;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
          end
        end else begin
          stable_q <= stable_d;
          for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
          end
        end
      end
    end else begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_q <= '0;
        else          stable_q <= s2_q;
      end
    end
  endgenerate

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_soc_system_pio_capture.sv
module tb_soc_system_pio_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  logic [7:0]  in0, in1;
  logic [31:0] in2;
  logic [4:0]  in3;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_system_pio_capture #(.WIDTH(8), .DEBOUNCE(0)) u_byp (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in0),
    .readdata(rd0), .irq(irq0));

  soc_system_pio_capture #(.WIDTH(8), .DEBOUNCE(4)) u_deb (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in1),
    .readdata(rd1), .irq(irq1));

  soc_system_pio_capture #(.WIDTH(32), .DEBOUNCE(0)) u_w32 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in2),
    .readdata(rd2), .irq(irq2));

  soc_system_pio_capture #(.WIDTH(5), .DEBOUNCE(0)) u_w5 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in3),
    .readdata(rd3), .irq(irq3));

  typedef struct {
    logic [7:0]  inp;
    logic        do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [25];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    // Each vector: drive in_port, let it settle, optional write, then a read.
    //            inp    wr    wa     wd            ra     exp_rd        irq
    tbl[0]  = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
    tbl[1]  = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd1, 32'h0,        1'b0};
    tbl[2]  = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
    tbl[3]  = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
    tbl[4]  = '{8'h00, 1'b1, 2'd2, 32'h01,       2'd2, 32'h01,       1'b0};
    tbl[5]  = '{8'h01, 1'b0, 2'd0, 32'h0,        2'd3, 32'h01,       1'b1};
    tbl[6]  = '{8'h01, 1'b0, 2'd0, 32'h0,        2'd0, 32'h01,       1'b1};
    tbl[7]  = '{8'h01, 1'b1, 2'd3, 32'h01,       2'd3, 32'h0,        1'b0};
    tbl[8]  = '{8'h01, 1'b1, 2'd1, 32'h1,        2'd1, 32'h1,        1'b0};
    tbl[9]  = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd3, 32'h01,       1'b1};
    tbl[10] = '{8'h00, 1'b1, 2'd3, 32'hFF,       2'd3, 32'h0,        1'b0};
    tbl[11] = '{8'h08, 1'b0, 2'd0, 32'h0,        2'd3, 32'h0,        1'b0};
    tbl[12] = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd3, 32'h08,       1'b0};
    tbl[13] = '{8'h00, 1'b1, 2'd1, 32'h2,        2'd3, 32'h08,       1'b0};
    tbl[14] = '{8'h00, 1'b1, 2'd3, 32'h08,       2'd3, 32'h0,        1'b0};
    tbl[15] = '{8'h08, 1'b0, 2'd0, 32'h0,        2'd3, 32'h08,       1'b0};
    tbl[16] = '{8'h08, 1'b1, 2'd3, 32'h08,       2'd3, 32'h0,        1'b0};
    tbl[17] = '{8'h00, 1'b0, 2'd0, 32'h0,        2'd3, 32'h08,       1'b0};
    tbl[18] = '{8'h00, 1'b1, 2'd3, 32'h08,       2'd3, 32'h0,        1'b0};
    tbl[19] = '{8'h08, 1'b1, 2'd1, 32'h3,        2'd3, 32'h08,       1'b0};
    tbl[20] = '{8'h08, 1'b1, 2'd3, 32'h08,       2'd3, 32'h08,       1'b0};
    tbl[21] = '{8'h08, 1'b1, 2'd2, 32'h08,       2'd2, 32'h08,       1'b1};
    tbl[22] = '{8'h00, 1'b1, 2'd3, 32'h08,       2'd3, 32'h0,        1'b0};
    tbl[23] = '{8'h00, 1'b1, 2'd0, 32'hFF,       2'd0, 32'h0,        1'b0};
    tbl[24] = '{8'h00, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h3,       1'b0};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Reset in the middle of traffic: irq must fall without a clock edge.
    wr(2'd2, 32'h01);
    in0 = 8'h01;
    repeat (6) tick();
    chk("pre_reset_irq", {31'b0, irq0}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_irq_drop", {31'b0, irq0}, 32'h0);
    chk("async_rd_clear", rd0, 32'h0);
    in0 = 8'h00;
    tick();
    chk("in_reset_irq", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      in0 = tbl[i].inp;
      repeat (6) tick();
      if (tbl[i].do_wr) wr(tbl[i].wa, tbl[i].wd);
      address = tbl[i].ra;
      tick();
      chk($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq0}, {31'b0, tbl[i].exp_irq});
    end

    // Rising capture latency: cap/irq at E0+3, not before.
    do_reset();
    wr(2'd2, 32'h01);
    in0 = 8'h01;
    repeat (3) tick();
    chk("lat_e2_irq", {31'b0, irq0}, 32'h0);
    tick();
    chk("lat_e3_irq", {31'b0, irq0}, 32'h1);
    address = 2'd0;
    tick();
    chk("lat_data", rd0, 32'h01);

    // Clear colliding with a fresh rising event: set must win.
    in0 = 8'h00;
    repeat (6) tick();
    wr(2'd3, 32'h01);
    chk("w1c_pre_clear", {31'b0, irq0}, 32'h0);
    in0 = 8'h01;
    repeat (3) tick();
    wr(2'd3, 32'h01);
    chk("w1c_set_wins", {31'b0, irq0}, 32'h1);
    wr(2'd3, 32'h01);
    chk("w1c_clear_irq", {31'b0, irq0}, 32'h0);
    address = 2'd3;
    tick();
    chk("w1c_clear_cap", rd0, 32'h0);

    // Debounce: 3-cycle glitch rejected, 6-cycle pulse accepted at E0+5.
    do_reset();
    wr(2'd2, 32'h04);
    in1 = 8'h04;
    repeat (3) tick();
    in1 = 8'h00;
    repeat (10) tick();
    chk("deb_glitch_irq", {31'b0, irq1}, 32'h0);
    address = 2'd0;
    tick();
    chk("deb_glitch_data", rd1, 32'h0);
    address = 2'd3;
    tick();
    chk("deb_glitch_cap", rd1, 32'h0);
    address = 2'd0;
    tick();
    in1 = 8'h04;
    repeat (6) tick();
    chk("deb_e5_data_old", rd1, 32'h0);
    chk("deb_e5_irq", {31'b0, irq1}, 32'h0);
    in1 = 8'h00;
    tick();
    chk("deb_e6_data_new", rd1, 32'h04);
    chk("deb_e6_irq", {31'b0, irq1}, 32'h1);
    address = 2'd3;
    tick();
    chk("deb_cap", rd1, 32'h04);

    // Width extremes: 32-bit masking and 5-bit zero-extended reads.
    do_reset();
    in2 = 32'hFFFF_FFFF;
    in3 = 5'h1F;
    repeat (6) tick();
    wr(2'd2, 32'h0);
    chk("w32_mask0_irq", {31'b0, irq2}, 32'h0);
    address = 2'd3;
    tick();
    chk("w32_cap_all", rd2, 32'hFFFF_FFFF);
    chk("w5_cap", rd3, 32'h0000_001F);
    wr(2'd2, 32'h8000_0000);
    chk("w32_msb_irq", {31'b0, irq2}, 32'h1);
    chk("w5_msb_irq", {31'b0, irq3}, 32'h0);
    address = 2'd0;
    tick();
    chk("w5_data", rd3, 32'h0000_001F);
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    tick();
    chk("w5_mask", rd3, 32'h0000_001F);
    chk("w5_irq", {31'b0, irq3}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
